// File: rtl/alu_mem_shifter_pkg.sv
// Shared definitions for the byte-to-serial ALU bridge: FSM states, byte index
// width and the transaction length helper.
package alu_mem_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        STORE = 2'd3
    } state_t;

    localparam int IDX_W = 1;

    // Number of bytes moved on each bus handshake phase.
    function automatic logic [IDX_W:0] bytes_per_txn(input logic pair);
        return pair ? (IDX_W+1)'(2) : (IDX_W+1)'(1);
    endfunction

endpackage

// File: rtl/mem_shift_buf.sv
// Two-byte operand/result buffer: byte write port, byte read mux and a serial
// shifter that works on either the low byte or the full buffer.
module mem_shift_buf
    import alu_mem_shifter_pkg::*;
#(
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [REG_BITS-1:0] wr_data,
    input  logic                shift_en,
    input  logic                pair,
    input  logic [NSHIFT-1:0]   ser_in,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [REG_BITS-1:0] rd_data,
    output logic [NSHIFT-1:0]   ser_out
);

    logic [2*REG_BITS-1:0] buf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q <= '0;
        end else if (clr) begin
            buf_q <= '0;
        end else if (wr_en) begin
            buf_q[wr_idx*REG_BITS +: REG_BITS] <= wr_data;
        end else if (shift_en) begin
            // Result bits enter at the top while the operand drains from the bottom.
            if (pair)
                buf_q <= {ser_in, buf_q[2*REG_BITS-1:NSHIFT]};
            else
                buf_q[REG_BITS-1:0] <= {ser_in, buf_q[REG_BITS-1:NSHIFT]};
        end
    end

    assign rd_data = buf_q[rd_idx*REG_BITS +: REG_BITS];
    assign ser_out = buf_q[NSHIFT-1:0];

endmodule

// File: rtl/alu_mem_shifter.sv
// Byte-to-serial bridge: loads 1 or 2 operand bytes, streams them to the ALU
// NSHIFT bits per active cycle while capturing the result, then returns it.
module alu_mem_shifter
    import alu_mem_shifter_pkg::*;
#(
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                pair,
    input  logic                load_arg,
    input  logic                store_result,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_BITS-1:0] in_data,
    output logic                alu_go,
    input  logic                alu_active,
    input  logic                alu_op_done,
    output logic [NSHIFT-1:0]   alu_data_in,
    input  logic [NSHIFT-1:0]   alu_data_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [REG_BITS-1:0] out_data,
    output logic                busy
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pair_q, load_q, store_q;
    logic                last_byte;
    logic                buf_clr;
    logic [REG_BITS-1:0] rd_data;
    logic [NSHIFT-1:0]   ser_out;

    assign last_byte = (({1'b0, idx_q} + 1'b1) == bytes_per_txn(pair_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pair_q  <= 1'b0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            pair_q  <= pair;
            load_q  <= load_arg;
            store_q <= store_result;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        buf_clr   = 1'b0;
        in_ready  = 1'b0;
        alu_go    = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d = '0;
                    if (load_arg) begin
                        state_d = LOAD;
                    end else begin
                        state_d = RUN;
                        buf_clr = 1'b1;
                    end
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (last_byte) begin
                        state_d = RUN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RUN: begin
                alu_go = 1'b1;
                if (alu_op_done) begin
                    idx_d   = '0;
                    state_d = store_q ? STORE : IDLE;
                end
            end
            STORE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_byte) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mem_shift_buf #(
        .REG_BITS (REG_BITS),
        .NSHIFT   (NSHIFT)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .clr      (buf_clr),
        .wr_en    (in_ready && in_valid),
        .wr_idx   (idx_q),
        .wr_data  (in_data),
        .shift_en (alu_go && alu_active),
        .pair     (pair_q),
        .ser_in   (alu_data_out),
        .rd_idx   (idx_q),
        .rd_data  (rd_data),
        .ser_out  (ser_out)
    );

    // Serial and byte outputs are forced quiet outside their own phase.
    assign alu_data_in = alu_go    ? ser_out : '0;
    assign out_data    = out_valid ? rd_data : '0;
    assign busy        = (state_q != IDLE);

    logic unused_load;
    assign unused_load = load_q;

endmodule
